// File: rtl/rv_mem_access_unit.sv
// rv_mem_access_unit: load/store controller between the core datapath and a single-port synchronous data RAM.
// Optional MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned or reserved-size accesses with rsp_err_o.
`default_nettype none

module rv_mem_access_unit #(
    parameter int RAM_AW   = 10,
    parameter int READ_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_din_o,
    output logic              ram_we_o,
    input  logic [31:0]       ram_dout_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    state_t              state_q;
    logic [1:0]          cnt_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [1:0]          lo_q;
    logic [15:0]         wdata_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q;
    logic                rsp_err_q;
    logic [RAM_AW-1:0]   ram_addr_q;
    logic [31:0]         ram_din_q;
    logic                ram_we_q;

    logic                req_err_d;
    logic [31:0]         load_data_d;
    logic [31:0]         merge_d;
    logic [7:0]          byte_d;
    logic [15:0]         half_d;
    logic                unused_addr_bits;

    // Address bits above the RAM window wrap and are intentionally dropped.
    assign unused_addr_bits = ^req_addr_i[31:RAM_AW+2];

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign req_err_d = (req_size_i == 2'b11)
                    || (req_size_i == 2'b01 && req_addr_i[0])
                    || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
`else
    assign req_err_d = 1'b0;
`endif

    always_comb begin
        byte_d      = ram_dout_i[8*lo_q +: 8];
        half_d      = lo_q[1] ? ram_dout_i[31:16] : ram_dout_i[15:0];
        load_data_d = ram_dout_i;
        merge_d     = ram_dout_i;
        case (size_q)
            2'b00: begin
                load_data_d           = {{24{~uns_q & byte_d[7]}}, byte_d};
                merge_d[8*lo_q +: 8]  = wdata_q[7:0];
            end
            2'b01: begin
                load_data_d = {{16{~uns_q & half_d[15]}}, half_d};
                if (lo_q[1]) merge_d[31:16] = wdata_q;
                else         merge_d[15:0]  = wdata_q;
            end
            default: begin
                load_data_d = ram_dout_i;
                merge_d     = ram_dout_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lo_q        <= 2'b00;
            wdata_q     <= 16'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= 32'h0;
            ram_we_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we_i;
                        size_q      <= req_size_i;
                        uns_q       <= req_unsigned_i;
                        lo_q        <= req_addr_i[1:0];
                        wdata_q     <= req_wdata_i[15:0];
                        ram_addr_q  <= req_addr_i[RAM_AW+1:2];
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                        if (req_err_d) begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else if (req_we_i && req_size_i[1]) begin
                            // Full-word store (reserved size folds to word) needs no read.
                            ram_din_q <= req_wdata_i;
                            ram_we_q  <= 1'b1;
                            state_q   <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    cnt_q   <= CNT_INIT;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        if (we_q) begin
                            ram_din_q <= merge_d;
                            ram_we_q  <= 1'b1;
                            state_q   <= S_WR;
                        end else begin
                            rsp_rdata_q <= load_data_d;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                S_WR: begin
                    ram_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    ram_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_din_o   = ram_din_q;
    assign ram_we_o    = ram_we_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_mem_access_unit.sv
// Bench for rv_mem_access_unit: directed scenarios plus random traffic against a byte-lane reference memory.
`default_nettype none

module tb_rv_mem_access_unit;

    localparam int AW  = 10;
    localparam int LAT = 1;
    localparam int NW  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din, ram_dout;
    logic          ram_we;

    always #5 clk = ~clk;

    rv_mem_access_unit #(.RAM_AW(AW), .READ_LAT(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .ram_addr_o(ram_addr),
        .ram_din_o(ram_din), .ram_we_o(ram_we), .ram_dout_i(ram_dout)
    );

    // Synchronous RAM with a backdoor write port for preloading.
    logic [31:0]   mem [0:NW-1];
    logic [31:0]   rd_pipe [0:1];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [31:0]   bd_data = 32'h0;

    always @(posedge clk) begin
        if (ram_we)     mem[ram_addr] <= ram_din;
        else if (bd_we) mem[bd_addr]  <= bd_data;
        rd_pipe[0] <= mem[ram_addr];
        rd_pipe[1] <= rd_pipe[0];
    end
    assign ram_dout = rd_pipe[LAT-1];

    logic [31:0] ref_mem [0:NW-1];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        return (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic int lane_off(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b00) return int'(addr[1:0]);
        if (size == 2'b01) return addr[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
        int nb = nbytes(size);
        logic [31:0] v = word >> (8 * lane_off(size, addr));
        logic [31:0] mask;
        if (nb == 4) return word;
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = v & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] wdata);
        int nb = nbytes(size);
        int sh = 8 * lane_off(size, addr);
        logic [31:0] mask;
        if (nb == 4) return wdata;
        mask = ((32'h1 << (8 * nb)) - 32'h1) << sh;
        return (word & ~mask) | ((wdata << sh) & mask);
    endfunction

    task automatic bd_write(input int idx, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = AW'(idx); bd_data = data;
        @(posedge clk);
        #1 bd_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat, output int wes);
        int w = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wes = 0;
        do begin
            @(negedge clk);
            lat++;
            if (ram_we) wes++;
        end while (!rsp_valid && lat < 40);
        rdata = rsp_rdata; err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int idx = int'(addr[AW+1:2]);
        logic e = ref_err(size, addr);
        logic [31:0] exp_rd = 32'h0;
        int exp_lat, exp_wes;
        logic [31:0] rd;
        logic er;
        int lat, wes;
        if (e)       begin exp_lat = 1; exp_wes = 0; end
        else if (!we) begin exp_lat = 2 + LAT; exp_wes = 0; exp_rd = ref_load(ref_mem[idx], size, uns, addr); end
        else if (size[1]) begin exp_lat = 2; exp_wes = 1; end
        else         begin exp_lat = 3 + LAT; exp_wes = 1; end
        do_req(we, size, uns, addr, wdata, rd, er, lat, wes);
        if (we && !e) ref_mem[idx] = ref_store(ref_mem[idx], size, addr, wdata);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, {31'b0, er}, {31'b0, e});
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".we_pulses"}, wes, exp_wes);
        if (we) check({tag, ".mem"}, mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] hold_d;
        int w;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.req_ready", {31'b0, req_ready}, 32'h1);
        check("rst.rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst.rsp_err",   {31'b0, rsp_err},   32'h0);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        check("rst.ram_we",    {31'b0, ram_we},    32'h0);
        check("rst.ram_addr",  {22'b0, ram_addr},  32'h0);
        check("rst.ram_din",   ram_din, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) bd_write(i, $urandom);

        run_req("wst40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
        run_req("wld40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        check("wld40.const", ref_mem[16], 32'hDEADBEEF);

        bd_write(8, 32'h11223344);
        run_req("bst22", 1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA);
        check("bst22.word", mem[8], 32'h11AA3344);
        run_req("bld22s", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0);
        run_req("bld22u", 1'b0, 2'b00, 1'b1, 32'h22, 32'h0);

        bd_write(12, 32'h80017FFF);
        run_req("hld32s", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
        run_req("hld30s", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0);

        // Response back-pressure: outputs hold and a stray request is ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'h32;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
        hold_d = rsp_rdata;
        check("stall.first", hold_d, 32'hFFFF8001);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h50; req_wdata = 32'h5555AAAA;
            end
            if (c == 2) req_valid = 1'b0;
            check("stall.valid", {31'b0, rsp_valid}, 32'h1);
            check("stall.rdata", rsp_rdata, hold_d);
            check("stall.ready", {31'b0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("stall.nowrite", mem[20], ref_mem[20]);

        run_req("wst42", 1'b1, 2'b10, 1'b0, 32'h42, 32'h0BADF00D);

        // Reset while the RMW write is on the RAM port.
        bd_write(4, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!ram_we && w < 20);
        check("rstwr.reached", {31'b0, ram_we}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rstwr.ram_we", {31'b0, ram_we}, 32'h0);
        check("rstwr.ready", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstwr.mem", mem[4], 32'hCAFEF00D);
        check("rstwr.rsp_valid", {31'b0, rsp_valid}, 32'h0);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom << (AW + 2)) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
